// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
//
// Instruction fetch / issue sequencer. It owns the program counter, reads one
// word at a time from instruction memory, latches it, announces it to the
// control unit with a one-cycle instr_valid pulse, and then waits for the
// datapath to finish before it works out the next pc from the decoded
// control bits.
//
// State flow:
//   FETCH -> WAIT -> ISSUE -> EXEC -> FETCH (or HALT -> FETCH on resume)
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a watchdog counts cycles spent in WAIT. After TMO_CYC cycles
//   without im_valid, the request is dropped for one cycle, the same pc is
//   re-fetched and the sticky fetch_err flag is set until reset. When not
//   defined, WAIT waits forever and fetch_err is tied low.
//
// Parameters:
//   ADDR_W   instruction-memory word-address width (pc width)
//   TMO_CYC  watchdog limit in WAIT cycles (FETCH_TIMEOUT_EN only, >= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   im_req       memory read request, held from FETCH until im_valid accepted
//   im_addr      memory word address, held with im_req
//   im_valid     memory read strobe, honoured only while im_req = 1
//   im_data      memory read data
//   instr        latched current instruction
//   opcode       instr[31:26] for the control unit
//   instr_valid  one-cycle pulse when a new instruction is issued
//   exec_done    datapath finished the issued instruction (EXEC only)
//   cu_Jump      jump to instr[ADDR_W-1:0]
//   cu_Branch    conditional branch, taken when alu_zero = 1
//   cu_hlt       halt, pc unchanged
//   cu_reset     restart from pc = 0
//   alu_zero     ALU zero flag
//   resume       leave HALT (HALT only)
//   pc           program counter
//   halted       high while in HALT
//   fetch_err    sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int ADDR_W  = 10,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_valid,
  input  logic [31:0]       im_data,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              cu_Jump,
  input  logic              cu_Branch,
  input  logic              cu_hlt,
  input  logic              cu_reset,
  input  logic              alu_zero,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    ISSUE,
    EXEC,
    HALT
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] pc_n;
  logic              im_req_n;
  logic [ADDR_W-1:0] im_addr_n;
  logic [31:0]       instr_n;
  logic              instr_valid_n;
  logic              halted_n;

  // Handshake and watchdog events, shared by the FSM and the watchdog block.
  logic fetch_accept;
  logic tmo_hit;
  logic tmo_fire;

  // Candidate next-pc values.
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_branch;

  assign opcode = instr[31:26];

  assign pc_inc    = pc + ADDR_W'(1);
  // Sign-extend (or truncate) the 16-bit branch offset to pc width; the sum
  // then wraps modulo 2^ADDR_W naturally.
  assign br_off    = ADDR_W'($signed(instr[15:0]));
  assign pc_branch = pc_inc + br_off;

  // Read data is only ever taken while a request is outstanding.
  assign fetch_accept = (state == WAIT) && im_req && im_valid;
  assign tmo_fire     = (state == WAIT) && !fetch_accept && tmo_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYC - 1));

  // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere, so
  // every fresh request (including a retry) gets the full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_fire) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_n       = state;
    pc_n          = pc;
    im_req_n      = im_req;
    im_addr_n     = im_addr;
    instr_n       = instr;
    instr_valid_n = 1'b0;
    halted_n      = halted;

    case (state)
      FETCH: begin
        im_req_n  = 1'b1;
        im_addr_n = pc;
        state_n   = WAIT;
      end

      WAIT: begin
        if (fetch_accept) begin
          instr_n  = im_data;
          im_req_n = 1'b0;
          state_n  = ISSUE;
        end else if (tmo_fire) begin
          // Drop the request for the FETCH cycle, then retry the same pc.
          im_req_n = 1'b0;
          state_n  = FETCH;
        end
      end

      ISSUE: begin
        instr_valid_n = 1'b1;
        state_n       = EXEC;
      end

      EXEC: begin
        if (exec_done) begin
          // Priority chain: a set higher bit makes all lower bits don't-care.
          if (cu_reset) begin
            pc_n    = '0;
            state_n = FETCH;
          end else if (cu_hlt) begin
            halted_n = 1'b1;
            state_n  = HALT;
          end else if (cu_Jump) begin
            pc_n    = instr[ADDR_W-1:0];
            state_n = FETCH;
          end else if (cu_Branch && alu_zero) begin
            pc_n    = pc_branch;
            state_n = FETCH;
          end else begin
            pc_n    = pc_inc;
            state_n = FETCH;
          end
        end
      end

      HALT: begin
        if (resume) begin
          halted_n = 1'b0;
          pc_n     = pc_inc;
          state_n  = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and program counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      im_req      <= 1'b0;
      im_addr     <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc          <= pc_n;
      im_req      <= im_req_n;
      im_addr     <= im_addr_n;
      instr       <= instr_n;
      instr_valid <= instr_valid_n;
      halted      <= halted_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_seq
//
// Self-checking bench for instr_fetch_seq. A table of hand-derived
// {start pc, instruction, control bits, expected pc} records covers the
// documented arithmetic and priority cases; a randomized phase then runs the
// sequencer against a word array and a next-pc reference function; finally a
// few hand-written sequences cover asynchronous reset mid-fetch and the
// long-wait / watchdog behaviour (FETCH_TIMEOUT_EN selects which).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_seq;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 15;
  localparam int BOUND = 50;

  logic          clk;
  logic          rst_n;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_valid;
  logic [31:0]   im_data;
  logic [31:0]   instr;
  logic [5:0]    opcode;
  logic          instr_valid;
  logic          exec_done;
  logic          cu_Jump;
  logic          cu_Branch;
  logic          cu_hlt;
  logic          cu_reset;
  logic          alu_zero;
  logic          resume;
  logic [AW-1:0] pc;
  logic          halted;
  logic          fetch_err;

  instr_fetch_seq #(.ADDR_W(AW), .TMO_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_valid   (im_valid),
    .im_data    (im_data),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .cu_Jump    (cu_Jump),
    .cu_Branch  (cu_Branch),
    .cu_hlt     (cu_hlt),
    .cu_reset   (cu_reset),
    .alu_zero   (alu_zero),
    .resume     (resume),
    .pc         (pc),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_pc;
  logic [31:0] mem [DEPTH];

  typedef struct {
    int          start_pc;
    logic [31:0] word;
    logic        rst;
    logic        hlt;
    logic        jmp;
    logic        br;
    logic        z;
    int          exp_pc;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next pc from the architectural rules, in plain integer arithmetic.
  function automatic int ref_next_pc(input int cur, input logic [31:0] word,
                                     input logic rst, input logic hlt, input logic jmp,
                                     input logic br, input logic z);
    int off;
    if (rst === 1'b1) return 0;
    if (hlt === 1'b1) return cur;
    if (jmp === 1'b1) return int'(word % DEPTH);
    if (br === 1'b1 && z === 1'b1) begin
      off = int'($signed(word[15:0]));
      return ((cur + 1 + off) % DEPTH + DEPTH) % DEPTH;
    end
    return (cur + 1) % DEPTH;
  endfunction

  // Serve one fetch: wait for im_req, check address, insert 'waits' stall
  // cycles, return 'word', then wait for the issue pulse and check it.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    int n;
    int lat;
    n = 0;
    while (im_req !== 1'b1) begin
      // Anything on these inputs while no request is pending must be ignored.
      im_valid  = 1'($urandom_range(0, 1));
      im_data   = $urandom;
      exec_done = 1'($urandom_range(0, 1));
      cu_Jump   = 1'b1;
      resume    = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (n > BOUND) begin
        $display("FAIL fetch_req_wait: im_req not seen within %0d cycles", BOUND);
        $fatal(1, "bench stopped");
      end
    end
    exec_done = 1'b0;
    resume    = 1'b0;
    lat = 0;
    check("fetch_addr", 32'(im_addr), 32'(model_pc));
    for (int k = 0; k < waits; k++) begin
      im_valid = 1'b0;
      @(negedge clk);
      lat++;
      check("req_held", 32'(im_req), 32'd1);
      check("addr_held", 32'(im_addr), 32'(model_pc));
    end
    im_valid = 1'b1;
    im_data  = word;
    @(negedge clk);
    lat++;
    // Request is gone now; a stray strobe here must not overwrite instr.
    im_valid = 1'($urandom_range(0, 1));
    im_data  = ~word;
    check("req_drop", 32'(im_req), 32'd0);
    n = 0;
    while (instr_valid !== 1'b1) begin
      @(negedge clk);
      lat++;
      n++;
      if (n > BOUND) begin
        $display("FAIL issue_wait: instr_valid not seen within %0d cycles", BOUND);
        $fatal(1, "bench stopped");
      end
    end
    im_valid = 1'b0;
    check("issue_latency", 32'(lat), 32'(waits + 2));
    check("instr", instr, word);
    check("opcode", 32'(opcode), 32'(word[31:26]));
  endtask

  // Complete the issued instruction with the given control bits and check pc.
  task automatic do_exec(input logic rst, input logic hlt, input logic jmp,
                         input logic br, input logic z, input int exp_pc);
    resume    = 1'b1;
    exec_done = 1'b0;
    @(negedge clk);
    resume = 1'b0;
    check("pulse_width", 32'(instr_valid), 32'd0);
    check("resume_ignored_pc", 32'(pc), 32'(model_pc));
    check("resume_ignored_halt", 32'(halted), 32'd0);
    exec_done = 1'b1;
    cu_reset  = rst;
    cu_hlt    = hlt;
    cu_Jump   = jmp;
    cu_Branch = br;
    alu_zero  = z;
    @(negedge clk);
    exec_done = 1'b0;
    cu_reset  = 1'($urandom_range(0, 1));
    cu_hlt    = 1'($urandom_range(0, 1));
    cu_Jump   = 1'($urandom_range(0, 1));
    cu_Branch = 1'($urandom_range(0, 1));
    alu_zero  = 1'($urandom_range(0, 1));
    check("exec_pc", 32'(pc), 32'(exp_pc));
    check("exec_halted", 32'(halted), (rst !== 1'b1 && hlt === 1'b1) ? 32'd1 : 32'd0);
    check("exec_no_req", 32'(im_req), 32'd0);
    if (rst !== 1'b1 && hlt === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        exec_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("halt_no_req", 32'(im_req), 32'd0);
        check("halt_held", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'(model_pc));
      end
      exec_done = 1'b0;
      resume    = 1'b1;
      @(negedge clk);
      resume   = 1'b0;
      model_pc = (model_pc + 1) % DEPTH;
      check("resume_halted", 32'(halted), 32'd0);
      check("resume_pc", 32'(pc), 32'(model_pc));
    end else begin
      model_pc = exp_pc;
    end
  endtask

  // Move the sequencer to pc = target with a jump instruction.
  task automatic goto_pc(input int target);
    logic [31:0] w;
    if (model_pc != target) begin
      w = 32'(target);
      do_fetch(w, 0);
      do_exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, target);
    end
  endtask

  initial begin
    int n;
    logic [31:0] w;
    logic r_rst, r_hlt, r_jmp, r_br, r_z;
    int r;

    vecs[0]  = '{0,    32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{3,    32'h5C00_0020, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32};
    vecs[2]  = '{5,    32'h1000_FFFD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vecs[3]  = '{5,    32'h1000_FFFD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6};
    vecs[4]  = '{1023, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1020, 32'h1000_0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[6]  = '{2,    32'h1000_8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vecs[7]  = '{7,    32'h0800_0155, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 341};
    vecs[8]  = '{9,    32'h1000_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[9]  = '{12,   32'hFC00_0000, 1'b0, 1'b1, 1'bx, 1'b1, 1'b1, 12};
    vecs[10] = '{1023, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[11] = '{100,  32'h1000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 101};
    vecs[12] = '{600,  32'h1000_FE00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 89};

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    rst_n     = 1'b0;
    im_valid  = 1'b0;
    im_data   = '0;
    exec_done = 1'b0;
    cu_Jump   = 1'b0;
    cu_Branch = 1'b0;
    cu_hlt    = 1'b0;
    cu_reset  = 1'b0;
    alu_zero  = 1'b0;
    resume    = 1'b0;
    model_pc  = 0;

    repeat (3) @(negedge clk);
    check("rst_im_req", 32'(im_req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(im_req), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      goto_pc(vecs[i].start_pc);
      do_fetch(vecs[i].word, $urandom_range(0, 2));
      do_exec(vecs[i].rst, vecs[i].hlt, vecs[i].jmp, vecs[i].br, vecs[i].z, vecs[i].exp_pc);
    end

    // Randomized program run against the word array and reference next-pc.
    for (int i = 0; i < 150; i++) begin
      w     = mem[model_pc];
      r     = $urandom_range(0, 15);
      r_rst = (r == 0);
      r_hlt = (r == 1);
      r_jmp = ($urandom_range(0, 3) == 0);
      r_br  = 1'($urandom_range(0, 1));
      r_z   = 1'($urandom_range(0, 1));
      do_fetch(w, $urandom_range(0, 3));
      do_exec(r_rst, r_hlt, r_jmp, r_br, r_z,
              ref_next_pc(model_pc, w, r_rst, r_hlt, r_jmp, r_br, r_z));
    end

    // Asynchronous reset while waiting on memory.
    goto_pc(682);
    n = 0;
    while (im_req !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > BOUND) begin
        $display("FAIL rst_req_wait: im_req not seen within %0d cycles", BOUND);
        $fatal(1, "bench stopped");
      end
    end
    im_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_pc", 32'(pc), 32'd682);
    rst_n = 1'b0;
    #1;
    check("async_rst_im_req", 32'(im_req), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_instr", instr, 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = 0;
    @(negedge clk);
    check("post_rst_req", 32'(im_req), 32'd1);
    check("post_rst_addr", 32'(im_addr), 32'd0);
    do_fetch(32'h0000_0000, 0);
    do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("zero_instr_pc", 32'(pc), 32'd1);

    // Slow memory: watchdog retry, or an unbounded wait without it.
    n = 0;
    while (im_req !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > BOUND) begin
        $display("FAIL slow_req_wait: im_req not seen within %0d cycles", BOUND);
        $fatal(1, "bench stopped");
      end
    end
    im_valid = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (im_req === 1'b1 && n < TMO + 5) begin
      @(negedge clk);
      n++;
    end
    check("tmo_req_cycles", 32'(n), 32'(TMO));
    check("tmo_fetch_err", 32'(fetch_err), 32'd1);
    @(negedge clk);
    check("tmo_retry_req", 32'(im_req), 32'd1);
    check("tmo_retry_addr", 32'(im_addr), 32'(model_pc));
`else
    repeat (40) @(negedge clk);
    check("long_wait_req", 32'(im_req), 32'd1);
    check("long_wait_addr", 32'(im_addr), 32'(model_pc));
    check("no_fetch_err", 32'(fetch_err), 32'd0);
`endif
    w = mem[model_pc];
    do_fetch(w, 0);
    do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (model_pc + 1) % DEPTH);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 SHALL have parameter TMO_CYC, default 15: fetch watchdog limit in cycles; used only when FETCH_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port im_req, output, 1: instruction-memory read request.
REQ-006 SHALL have port im_addr, output, ADDR_W: read word address.
REQ-007 SHALL have ports im_valid, input, 1 and im_data, input, 32: read data strobe and read data.
REQ-008 SHALL have port instr, output, 32: latched current instruction.
REQ-009 SHALL have port opcode, output, 6: instr[31:26], driven to the control unit.
REQ-010 SHALL have port instr_valid, output, 1: one-cycle pulse when a new instruction is issued.
REQ-011 SHALL have port exec_done, input, 1: datapath completed the issued instruction.
REQ-012 SHALL have inputs cu_Jump, cu_Branch, cu_hlt, cu_reset and alu_zero, 1 bit each: decoded control bits plus the ALU zero flag.
REQ-013 SHALL have port resume, input, 1: leave HALT.
REQ-014 SHALL have ports pc, output, ADDR_W and halted, output, 1.
REQ-015 SHALL have port fetch_err, output, 1: sticky fetch-timeout flag.

Function
REQ-016 SHALL implement FSM states FETCH, WAIT, ISSUE, EXEC and HALT.
REQ-017 FETCH SHALL assert im_req with im_addr=pc, then go to WAIT on the next cycle.
REQ-018 im_req and im_addr SHALL be held stable from FETCH until the cycle im_valid=1 is sampled.
REQ-019 im_valid SHALL be accepted in any cycle im_req=1, including the first; it SHALL be ignored when im_req=0.
REQ-020 On im_valid accept: instr<=im_data, im_req<=0, next state ISSUE.
REQ-021 ISSUE SHALL drive instr_valid=1 for exactly one cycle, then go to EXEC.
REQ-022 Minimum fetch-to-issue latency SHALL be 2 cycles: im_req rising edge to instr_valid rising edge with zero-wait memory.
REQ-023 EXEC SHALL wait for exec_done, then sample control bits and update pc at that same edge.
REQ-024 Update priority SHALL be: cu_reset > cu_hlt > cu_Jump > (cu_Branch&alu_zero) > increment.
REQ-025 Lower-priority control inputs SHALL be don't-care, including X, when a higher-priority input is 1.
REQ-026 cu_reset SHALL set pc<=0 and next state FETCH.
REQ-027 cu_hlt SHALL leave pc unchanged, set halted=1 and next state HALT.
REQ-028 cu_Jump SHALL set pc<=instr[ADDR_W-1:0].
REQ-029 A taken branch SHALL set pc<=pc+1+sign-extended instr[15:0], truncated modulo 2^ADDR_W.
REQ-030 The default update SHALL be pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
REQ-031 HALT SHALL hold all outputs until resume=1, then clear halted, set pc<=pc+1 and go to FETCH.
REQ-032 exec_done SHALL be ignored outside EXEC.
REQ-033 resume SHALL be ignored outside HALT.

Reset
REQ-034 rst_n=0 SHALL asynchronously set state=FETCH, pc=0, im_req=0, instr=0, instr_valid=0, halted=0 and fetch_err=0, in any state including mid-fetch.
REQ-035 The first im_req SHALL assert on the first clk edge after rst_n deasserts.

Configuration
REQ-036 With FETCH_TIMEOUT_EN defined, a counter SHALL run in WAIT.
REQ-037 After TMO_CYC cycles in WAIT without im_valid, the block SHALL drop im_req for one cycle, re-enter FETCH with the same pc, and set fetch_err=1 until reset.
REQ-038 Without FETCH_TIMEOUT_EN, WAIT SHALL wait indefinitely and fetch_err SHALL be tied to 0.

Verification
REQ-039 Release reset, zero-wait memory returning 0x00000000 at addr 0, exec_done one cycle after issue -> instr_valid pulses, opcode=0, pc=1.
REQ-040 Instruction 0x5C000020 at pc=3 with cu_Jump=1 at exec_done -> pc=0x020, next im_addr=0x020.
REQ-041 pc=5, cu_Branch=1, alu_zero=1, instr[15:0]=0xFFFD -> pc=3; same with alu_zero=0 -> pc=6; pc=1023 with no control bits set -> pc=0.
REQ-042 cu_hlt=1 with cu_Jump=X -> halted=1, pc unchanged, no im_req; resume pulse -> pc+1 fetched.
REQ-043 rst_n=0 mid-WAIT -> im_req=0 immediately, pc=0; with FETCH_TIMEOUT_EN, im_valid withheld 15 cycles -> im_req re-asserts at the same address and fetch_err=1.
